// File: rtl/brcomp.sv
// brcomp: RV32I branch comparator for the execute stage.
//
// Produces same-cycle "less than" and "equal" flags for two register operands, plus a copy of
// each flag registered one cycle later for downstream pipeline/hazard logic.
//
// Ports:
//   clk_i          clock; registered flags update on the rising edge
//   rst_ni         asynchronous active-low reset, clears the registered flags
//   rs1_data_i     first operand (rs1)
//   rs2_data_i     second operand (rs2)
//   br_unsigned_i  1 = unsigned compare (BLTU/BGEU), 0 = signed compare
//   br_less_o      combinational: rs1 < rs2 under the selected signedness
//   br_equal_o     combinational: rs1 == rs2, bit-exact
//   br_less_r_o    br_less_o registered one cycle
//   br_equal_r_o   br_equal_o registered one cycle
//
// Optional feature (macro BRCOMP_GE_EN):
//   br_ge_o        combinational: rs1 >= rs2 (inverse of br_less_o)
//   br_ge_r_o      br_ge_o registered one cycle
module brcomp #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            br_unsigned_i,
  output logic            br_less_o,
  output logic            br_equal_o,
  output logic            br_less_r_o,
  output logic            br_equal_r_o
`ifdef BRCOMP_GE_EN
  ,
  output logic            br_ge_o,
  output logic            br_ge_r_o
`endif
);

  logic [XLEN:0] rs1_ext;
  logic [XLEN:0] rs2_ext;
  logic [XLEN:0] diff;

  logic less_q;
  logic equal_q;

  // One extra bit is enough to hold the true sign of the difference in both modes: it is a
  // zero-extension for unsigned and a sign-extension for signed operands.
  always_comb begin
    rs1_ext    = {(~br_unsigned_i) & rs1_data_i[XLEN-1], rs1_data_i};
    rs2_ext    = {(~br_unsigned_i) & rs2_data_i[XLEN-1], rs2_data_i};
    diff       = rs1_ext - rs2_ext;
    br_less_o  = diff[XLEN];
    br_equal_o = (rs1_data_i == rs2_data_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      less_q  <= 1'b0;
      equal_q <= 1'b0;
    end else begin
      less_q  <= br_less_o;
      equal_q <= br_equal_o;
    end
  end

  assign br_less_r_o  = less_q;
  assign br_equal_r_o = equal_q;

`ifdef BRCOMP_GE_EN
  logic ge_q;

  assign br_ge_o = ~br_less_o;

  // Kept as its own flop rather than ~less_q so that it reads 0 during reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ge_q <= 1'b0;
    end else begin
      ge_q <= br_ge_o;
    end
  end

  assign br_ge_r_o = ge_q;
`endif

endmodule

// File: tb/tb_brcomp.sv
// Self-checking bench for brcomp: combinational flags checked against a reference model the
// same cycle, expected registered flags queued and compared after the next rising edge.
module tb_brcomp;

  logic        clk;
  logic        rst_n;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        uns;
  logic        less;
  logic        equal;
  logic        less_r;
  logic        equal_r;
`ifdef BRCOMP_GE_EN
  logic        ge;
  logic        ge_r;
`endif

  typedef struct packed {
    logic less;
    logic equal;
    logic ge;
  } exp_t;

  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;

  brcomp #(
    .XLEN(32)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .rs1_data_i   (rs1),
    .rs2_data_i   (rs2),
    .br_unsigned_i(uns),
    .br_less_o    (less),
    .br_equal_o   (equal),
    .br_less_r_o  (less_r),
    .br_equal_r_o (equal_r)
`ifdef BRCOMP_GE_EN
    ,
    .br_ge_o      (ge),
    .br_ge_r_o    (ge_r)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (rs1=%h rs2=%h uns=%b)", tag, got, exp, rs1, rs2, uns);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic u);
    exp_t e;
    e.less  = u ? (a < b) : ($signed(a) < $signed(b));
    e.equal = (a == b);
    e.ge    = ~e.less;
    return e;
  endfunction

  // Drive on the falling edge, check the combinational flags, then compare the queued
  // expectation against the registered flags just after the following rising edge.
  task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic u);
    exp_t e;
    exp_t r;
    @(negedge clk);
    rs1 = a;
    rs2 = b;
    uns = u;
    e = model(a, b, u);
    exp_q.push_back(e);
    #1;
    check("less", less, e.less);
    check("equal", equal, e.equal);
    check("never_both", less & equal, 1'b0);
`ifdef BRCOMP_GE_EN
    check("ge", ge, e.ge);
`endif
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("queue_empty", 1'b1, 1'b0);
    end else begin
      r = exp_q.pop_front();
      check("less_r", less_r, r.less);
      check("equal_r", equal_r, r.equal);
`ifdef BRCOMP_GE_EN
      check("ge_r", ge_r, r.ge);
`endif
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rs1   = 32'h0;
    rs2   = 32'h1;
    uns   = 1'b1;
    #3;
    check("rst_less_r", less_r, 1'b0);
    check("rst_equal_r", equal_r, 1'b0);
`ifdef BRCOMP_GE_EN
    check("rst_ge_r", ge_r, 1'b0);
`endif
    @(posedge clk);
    #1;
    check("rst_hold_less_r", less_r, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed test plan and boundary cases
    apply(32'h0000_0000, 32'h0000_0001, 1'b1);
    apply(32'h0000_0000, 32'h0000_0000, 1'b1);
    apply(32'h0000_0000, 32'h0000_0000, 1'b0);
    apply(32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
    apply(32'h0000_0000, 32'hFFFF_FFFF, 1'b1);
    apply(32'hF0AB_0000, 32'h8902_AF77, 1'b1);
    apply(32'h10FF_6677, 32'h6902_AF77, 1'b0);
    apply(32'hFF0B_7ABC, 32'hFFFA_7BC0, 1'b0);
    apply(32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
    apply(32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
    apply(32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
    apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = (i % 5 == 0) ? a : $urandom;
      if (i % 7 == 0) b = a ^ 32'h8000_0000;
      apply(a, b, 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset mid-cycle while the registered less flag is 1
    apply(32'h0000_0000, 32'h0000_0001, 1'b1);
    check("pre_rst_less_r", less_r, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_less_r", less_r, 1'b0);
    check("async_rst_equal_r", equal_r, 1'b0);
    @(negedge clk);
    rs1   = 32'd5;
    rs2   = 32'd5;
    uns   = 1'b0;
    rst_n = 1'b1;
    #1;
    check("rel_equal_comb", equal, 1'b1);
    check("rel_equal_r_before", equal_r, 1'b0);
    @(posedge clk);
    #1;
    check("rel_equal_r_after", equal_r, 1'b1);
    check("rel_less_r_after", less_r, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
